bleeper_pcm: RTL and testbench
==============================

// Module: bleeper_pcm
// PURPOSE
//  Converts the 1-bit PCW bleeper speaker square wave into a signed 16-bit PCM sample stream for the audio mixer/codec path.
//  Measures the speaker duty cycle over a fixed window of ce ticks and maps it to a bipolar level.
//  Scales that level by an attack/release envelope so beeper gating never produces clicks.
//  Sits between the bleeper tone generator and the board audio output.
// PARAMETERS
//  LOG2_WIN   10     window length = 2**LOG2_WIN ce ticks; legal range 1..15 (64MHz/1024 = 62.5kHz sample rate)
//  RAMP_STEP  512    envelope increment/decrement per window, unsigned 15-bit, must be >0
// PORTS
//  clk_sys       in   1   system clock
//  reset_n       in   1   asynchronous reset, active-low
//  ce            in   1   clock enable; window counting advances only when high
//  enable        in   1   beeper gate from I/O decode; sampled at window end only
//  speaker_in    in   1   square wave from bleeper (may be from another domain)
//  sample        out  16  signed PCM sample, held between updates
//  sample_valid  out  1   one clk_sys pulse when sample updates
//  active        out  1   high while envelope != 0
// BEHAVIOUR
//  Reset: sample=0, sample_valid=0, active=0, env=0, state=IDLE, all counters 0, synchronizer flops 0.
//  Input: speaker_in passes through a 2-flop synchronizer clocked every clk_sys (not gated by ce) -> spk_s.
//  Window: win_cnt (LOG2_WIN bits) increments on each ce; wraps naturally at 2**LOG2_WIN-1 -> 0.
//   high_cnt (LOG2_WIN+1 bits) += spk_s on each ce.
//   Window end (WE) = ce && win_cnt == all-ones; high_tot = high_cnt + spk_s (current tick counted); high_cnt <= 0.
//  Level: bip = 2*high_tot - 2**LOG2_WIN (signed, range +/-2**LOG2_WIN).
//   bip_q = bip << (15-LOG2_WIN), saturated to [-32768, 32767].
//  Envelope env: unsigned 15-bit (0..32767); FSM updates on WE only. env_next is the post-update value.
//   IDLE: env=0. enable=1 -> ATTACK, and env_next = min(RAMP_STEP, 32767).
//   ATTACK: enable=0 -> RELEASE (env_next = env - step, floor 0).
//    Otherwise env_next = env + step, saturating at 32767; reaching 32767 -> HOLD.
//   HOLD: env=32767. enable=0 -> RELEASE with env_next = 32767 - step.
//   RELEASE: enable=1 -> ATTACK (env_next = env + step, sat; -> HOLD if 32767).
//    Otherwise env_next = env - step, floor 0; reaching 0 -> IDLE.
//   All transitions are evaluated in the same WE cycle as the env_next computation shown for that transition.
//  Output: on the WE cycle, register sample <= (bip_q * env_next) >>> 15.
//   The product is signed 16 x unsigned 15 -> 31-bit signed, arithmetic shift (floor).
//   The result always fits 16 bits without saturation.
//   sample_valid is asserted the clk_sys cycle after WE (1-cycle latency from WE; sample already stable).
//   sample_valid is high for exactly one clk_sys cycle.
//  active = (env != 0), registered with env.
//  ce low: win_cnt, high_cnt and FSM frozen; no sample_valid. The synchronizer still runs. A window spans exactly 2**LOG2_WIN ce ticks.
//  enable changes between WEs are ignored; only the level at WE matters.
//  reset_n low mid-window: all state clears immediately (async). After release, the first window starts at win_cnt=0.
// TESTING (LOG2_WIN=4, RAMP_STEP=8192 unless noted; ce=1 continuously)
//  1 Reset: hold reset_n=0 with random inputs -> sample=0, sample_valid=0, active=0; release -> first sample_valid exactly 17 clk after.
//  2 enable=1, speaker_in=1 constant -> samples 8191, 16383, 24575, 32766, 32766...; FSM ATTACK x3 then HOLD; active=1 from window 1.
//  3 HOLD, speaker_in toggling every 8 ce (50% duty, aligned to window) -> sample 0 each window.
//  4 HOLD, speaker_in=0 constant -> sample -32767 each window (bip_q = -32768, env 32767).
//  5 HOLD, drop enable -> env 24575, 16383, 8191, 0; samples scale accordingly; active falls with last window; state IDLE.
//    Re-raise enable when env=16383 -> next env 24575 (ATTACK from current value, no jump).
//  6 ce duty 1/3 -> window = 16 ce = 48 clk, sample_valid every 48 clk.
//    reset_n pulse mid-window -> outputs 0 at once; counts restart clean.

Source files
------------

// File: rtl/bleeper_pcm.sv
// -----------------------------------------------------------------------------
// bleeper_pcm
//
// Turns the 1-bit bleeper speaker square wave into a signed 16-bit PCM stream.
// The speaker duty cycle is measured over a window of 2**LOG2_WIN ce ticks and
// mapped onto a bipolar full-scale level. That level is scaled by an
// attack/release envelope so that gating the beeper on and off ramps the
// output instead of stepping it, which keeps the mixer free of clicks.
//
// Parameters
//   LOG2_WIN   : window length is 2**LOG2_WIN ce ticks (1..15)
//   RAMP_STEP  : envelope change per window, unsigned 15-bit, > 0
//
// Ports
//   clk_sys      in   system clock
//   reset_n      in   asynchronous reset, active-low
//   ce           in   clock enable; the window only advances while high
//   enable       in   beeper gate, only looked at on the last tick of a window
//   speaker_in   in   bleeper square wave, may come from another clock domain
//   sample       out  signed PCM sample, held between updates
//   sample_valid out  single-cycle pulse marking a new sample
//   active       out  high while the envelope is non-zero
// -----------------------------------------------------------------------------
module bleeper_pcm #(
    parameter int unsigned LOG2_WIN  = 10,
    parameter int unsigned RAMP_STEP = 512
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               enable,
    input  logic               speaker_in,
    output logic signed [15:0] sample,
    output logic               sample_valid,
    output logic               active
);

    localparam int unsigned   WIN     = 1 << LOG2_WIN;
    localparam logic [14:0]   ENV_MAX = 15'h7FFF;
    localparam logic [14:0]   STEP    = 15'(RAMP_STEP);
    localparam logic [LOG2_WIN-1:0] WIN_ONE = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // Clamp an 18-bit intermediate onto the 16-bit PCM range.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7FFF;
        end
        if (v < -18'sd32768) begin
            return 16'sh8000;
        end
        return v[15:0];
    endfunction

    // Window high count -> full-scale bipolar level. A window that is high
    // throughout lands on +32768 and is clamped to +32767; all-low gives
    // exactly -32768.
    function automatic logic signed [15:0] level_of(input logic [LOG2_WIN:0] hi);
        logic [17:0]        twice;
        logic signed [17:0] bip;
        twice = 18'(hi) << 1;
        bip   = $signed(twice - 18'(WIN));
        return sat16(bip <<< (15 - LOG2_WIN));
    endfunction

    function automatic logic [14:0] env_up(input logic [14:0] e);
        logic [15:0] s;
        s = {1'b0, e} + {1'b0, STEP};
        if (s > 16'd32767) begin
            return ENV_MAX;
        end
        return s[14:0];
    endfunction

    function automatic logic [14:0] env_down(input logic [14:0] e);
        if (e > STEP) begin
            return e - STEP;
        end
        return 15'd0;
    endfunction

    // Signed level times unsigned envelope, floored by 2**15. The magnitude of
    // the product stays below 2**30, so the quotient always fits 16 bits.
    function automatic logic signed [15:0] scale(input logic signed [15:0] lvl,
                                                 input logic [14:0]        e);
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [31:0] p;
        a = 32'(lvl);
        b = $signed({17'd0, e});
        p = a * b;
        return 16'(p >>> 15);
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic                  sync1_q;
    logic                  spk_s_q;
    logic [LOG2_WIN-1:0]   win_cnt_q;
    logic [LOG2_WIN:0]     high_cnt_q;
    state_t                state_q;
    state_t                state_d;
    logic [14:0]           env_q;
    logic [14:0]           env_d;
    logic signed [15:0]    sample_q;
    logic                  valid_q;
    logic                  active_q;

    logic                  we;
    logic [LOG2_WIN:0]     high_tot;
    logic signed [15:0]    level;
    logic signed [15:0]    sample_d;

    // -------------------------------------------------------------------------
    // Window-end stage: duty measurement and envelope step
    // -------------------------------------------------------------------------
    assign we       = ce && (win_cnt_q == '1);
    // The tick that closes the window is counted as well.
    assign high_tot = high_cnt_q + (LOG2_WIN+1)'(spk_s_q);
    assign level    = level_of(high_tot);

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (we) begin
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        env_d   = env_up(15'd0);
                        state_d = ATTACK;
                    end
                end
                ATTACK: begin
                    if (!enable) begin
                        env_d   = env_down(env_q);
                        state_d = RELEASE;
                    end else begin
                        env_d = env_up(env_q);
                        if (env_d == ENV_MAX) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        env_d   = env_down(ENV_MAX);
                        state_d = RELEASE;
                    end else begin
                        env_d = ENV_MAX;
                    end
                end
                RELEASE: begin
                    // Re-gating ramps up from wherever the release got to.
                    if (enable) begin
                        env_d   = env_up(env_q);
                        state_d = (env_d == ENV_MAX) ? HOLD : ATTACK;
                    end else begin
                        env_d = env_down(env_q);
                        if (env_d == 15'd0) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    env_d   = 15'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The sample uses the post-update envelope so it tracks the ramp without
    // an extra window of lag.
    assign sample_d = scale(level, env_d);

    // -------------------------------------------------------------------------
    // Output stage: sample, valid and active registered together
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            spk_s_q    <= 1'b0;
            win_cnt_q  <= '0;
            high_cnt_q <= '0;
            state_q    <= IDLE;
            env_q      <= 15'd0;
            sample_q   <= 16'sd0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            // Synchronizer runs every clock regardless of ce.
            sync1_q <= speaker_in;
            spk_s_q <= sync1_q;
            if (ce) begin
                win_cnt_q  <= win_cnt_q + WIN_ONE;
                high_cnt_q <= we ? '0 : high_tot;
            end
            state_q  <= state_d;
            env_q    <= env_d;
            active_q <= (env_d != 15'd0);
            valid_q  <= we;
            if (we) begin
                sample_q <= sample_d;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign active       = active_q;

endmodule

// File: tb/tb_bleeper_pcm.sv
// -----------------------------------------------------------------------------
// tb_bleeper_pcm
//
// Directed bench for bleeper_pcm with LOG2_WIN=4, RAMP_STEP=8192. A reference
// model computes each window's expected sample from the duty count and an
// envelope rule (enabled: add step up to full scale; disabled: subtract step
// down to zero); every cycle the DUT outputs are compared against it, and
// hand-computed sample values pin the model at key points.
// -----------------------------------------------------------------------------
module tb_bleeper_pcm;

    localparam int L    = 4;
    localparam int STEP = 8192;
    localparam int WIN  = 16;
    localparam int EMAX = 32767;

    logic               clk_sys    = 1'b0;
    logic               reset_n    = 1'b1;
    logic               ce         = 1'b0;
    logic               enable     = 1'b0;
    logic               speaker_in = 1'b0;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               active;

    bleeper_pcm #(.LOG2_WIN(L), .RAMP_STEP(STEP)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce          (ce),
        .enable      (enable),
        .speaker_in  (speaker_in),
        .sample      (sample),
        .sample_valid(sample_valid),
        .active      (active)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors     = 0;
    int miscompares = 0;
    int spk_mode    = 0;   // 0 low, 1 high, 2 square wave period 16, 3 random
    int ce_mode     = 0;   // 0 always, 1 one clock in three, 2 random
    int tcnt        = 0;

    // ---------------- reference model ----------------
    int m_h1 = 0, m_h2 = 0, m_ticks = 0, m_highs = 0, m_env = 0;
    int exp_sample = 0;
    bit exp_valid  = 1'b0;
    bit exp_active = 1'b0;

    function automatic int next_env(input int e, input bit en);
        if (en) return (e + STEP > EMAX) ? EMAX : e + STEP;
        return (e - STEP < 0) ? 0 : e - STEP;
    endfunction

    // highs out of WIN ticks -> level in [-32768, 32767], times env / 32768 floored
    function automatic int expect_sample(input int highs, input int env);
        longint lev, p, q;
        lev = longint'(2 * highs - WIN) * (32768 / WIN);
        if (lev > 32767) lev = 32767;
        p = lev * env;
        q = p / 32768;
        if ((p % 32768 != 0) && (p < 0)) q = q - 1;
        return int'(q);
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_h1 <= 0; m_h2 <= 0; m_ticks <= 0; m_highs <= 0; m_env <= 0;
            exp_sample <= 0; exp_valid <= 1'b0; exp_active <= 1'b0;
        end else begin
            // speaker level seen by the counter is the input two clocks ago
            m_h1 <= int'(speaker_in);
            m_h2 <= m_h1;
            exp_valid <= 1'b0;
            if (ce) begin
                if (m_ticks == WIN - 1) begin
                    m_ticks    <= 0;
                    m_highs    <= 0;
                    m_env      <= next_env(m_env, enable);
                    exp_sample <= expect_sample(m_highs + m_h2, next_env(m_env, enable));
                    exp_active <= (next_env(m_env, enable) != 0);
                    exp_valid  <= 1'b1;
                end else begin
                    m_ticks <= m_ticks + 1;
                    m_highs <= m_highs + m_h2;
                end
            end
        end
    end

    // ---------------- checking / driving ----------------
    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // One clock: compare outputs against the model, then drive the next inputs.
    task automatic tick();
        @(negedge clk_sys);
        check("sample", int'(sample), exp_sample);
        check("sample_valid", int'(sample_valid), int'(exp_valid));
        check("active", int'(active), int'(exp_active));
        tcnt++;
        case (spk_mode)
            0:       speaker_in = 1'b0;
            1:       speaker_in = 1'b1;
            2:       speaker_in = ((tcnt / 8) % 2) == 1;
            default: speaker_in = ($urandom_range(1, 0) == 1);
        endcase
        case (ce_mode)
            0:       ce = 1'b1;
            1:       ce = (tcnt % 3) == 0;
            default: ce = ($urandom_range(1, 0) == 1);
        endcase
    endtask

    task automatic wait_valid(output int clks, output int ces);
        int c;
        clks = 0;
        ces  = 0;
        do begin
            c = ce ? 1 : 0;
            tick();
            clks++;
            ces += c;
        end while (!sample_valid && clks < 300);
        if (!sample_valid) check("valid_timeout", int'(sample_valid), 1);
    endtask

    task automatic expect_win(input string name, input int req);
        int n, c;
        wait_valid(n, c);
        check(name, int'(sample), req);
    endtask

    initial begin
        int n, c;
        #1 reset_n = 1'b0;

        // 1: reset with random inputs, then count to the first valid
        spk_mode = 3;
        ce_mode  = 2;
        repeat (6) begin
            tick();
            enable = ($urandom_range(1, 0) == 1);
        end
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_active", int'(active), 0);
        spk_mode = 1;
        ce_mode  = 0;
        enable   = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_valid(n, c);
        // pulse is high in the cycle ending at the 17th rising edge after release
        check("first_valid_edge", n + 1, 17);
        check("first_window_ce", c, WIN);
        check("idle_sample", int'(sample), 0);
        check("idle_active", int'(active), 0);

        // 2: attack with speaker high throughout
        enable = 1'b1;
        expect_win("attack1", 8191);
        check("attack1_active", int'(active), 1);
        expect_win("attack2", 16383);
        expect_win("attack3", 24575);
        expect_win("hold1", 32766);
        expect_win("hold2", 32766);

        // 3: 50% duty square wave
        spk_mode = 2;
        wait_valid(n, c);
        expect_win("duty50_a", 0);
        expect_win("duty50_b", 0);

        // 4: speaker low, plus an enable glitch between window ends
        spk_mode = 0;
        wait_valid(n, c);
        expect_win("low_a", -32767);
        repeat (5) tick();
        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        expect_win("low_glitch", -32767);

        // 5: release to idle, re-attack, release then re-gate mid-ramp
        enable = 1'b0;
        expect_win("rel1", -24575);
        expect_win("rel2", -16383);
        expect_win("rel3", -8191);
        expect_win("rel4", 0);
        check("rel4_active", int'(active), 0);
        expect_win("idle_again", 0);
        check("idle_again_active", int'(active), 0);
        enable = 1'b1;
        expect_win("reatt1", -8192);
        expect_win("reatt2", -16384);
        expect_win("reatt3", -24576);
        expect_win("reatt4", -32767);
        enable = 1'b0;
        expect_win("rel_b1", -24575);
        expect_win("rel_b2", -16383);
        enable = 1'b1;
        expect_win("regate", -24575);
        expect_win("regate_hold", -32767);

        // 6: ce one clock in three, then async reset mid-window
        ce_mode  = 1;
        spk_mode = 1;
        wait_valid(n, c);
        wait_valid(n, c);
        check("ce3_period_clk", n, 48);
        check("ce3_period_ce", c, WIN);
        wait_valid(n, c);
        check("ce3_period_clk2", n, 48);
        repeat (20) tick();
        #1 reset_n = 1'b0;
        #1;
        check("midrst_sample", int'(sample), 0);
        check("midrst_valid", int'(sample_valid), 0);
        check("midrst_active", int'(active), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        wait_valid(n, c);
        check("post_rst_ce", c, WIN);
        check("post_rst_active", int'(active), 1);
        wait_valid(n, c);
        check("post_rst_period", n, 48);
        check("post_rst_sample2", int'(sample), 16383);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
